// File: rtl/img2col_pkg.sv
// img2col_pkg: shared widths, defaults and state types for the img2col block.
package img2col_pkg;
  localparam int DATA_W = 64;
  localparam int BYTES_PER_BEAT = 8;
  localparam int MAX_ROW_BEATS = 2048;
  localparam int ROW_SLOTS = 8;
  localparam int CNT_W = 16;
  localparam int SUM_W = CNT_W + 2;
  typedef struct packed {
    logic last;
    logic row_end;
    logic [CNT_W-1:0] row;
  } tag_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_t tag;
  } beat_t;
  typedef struct packed {
    logic active;
    logic [CNT_W-1:0] wrow;
    logic [CNT_W-1:0] wcol;
    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] rbase;
    logic [CNT_W-1:0] oct;
    logic [CNT_W-1:0] c;
    logic [CNT_W-1:0] colbase;
    logic [CNT_W-1:0] kr;
    logic [CNT_W-1:0] beat;
    logic infl;
    tag_t infl_tag;
    beat_t [1:0] fifo;
    logic [1:0] cnt;
    logic head;
    logic test_end;
  } st_t;
endpackage

// File: rtl/img2col_if.sv
// img2col_if: pixel input stream and img2col output stream.
interface img2col_if;
  import img2col_pkg::*;
  logic sData_valid;
  logic sData_ready;
  logic [DATA_W-1:0] sData_payload;
  logic [DATA_W-1:0] mData;
  logic mValid;
  logic mLast;
  logic mReady;
  modport slave (input sData_valid, sData_payload, mReady, output sData_ready, mData, mValid, mLast);
  modport master (output sData_valid, sData_payload, mReady, input sData_ready, mData, mValid, mLast);
endinterface

// File: rtl/img2col_linebuf.sv
// img2col_linebuf: simple dual-port line buffer with a registered read port.
module img2col_linebuf
  import img2col_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata_q
);
  logic [DATA_W-1:0] mem [1 << AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
endmodule

// File: rtl/img2col_top.sv
// img2col_top: buffers input rows in a line buffer and streams them out in
// img2col order through a 2-entry skid buffer hiding the RAM read latency.
module img2col_top #(
  parameter int MAX_ROW_BEATS = img2col_pkg::MAX_ROW_BEATS,
  parameter int ROW_SLOTS = img2col_pkg::ROW_SLOTS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  img2col_if.slave    io,
  input  logic [7:0]  Stride,
  input  logic [7:0]  Kernel_Size,
  input  logic [15:0] InFeature_Size,
  input  logic [15:0] InFeature_Channel,
  input  logic [15:0] OutFeature_Channel,
  input  logic [15:0] OutFeature_Size,
  input  logic [15:0] Window_Size,
  input  logic [15:0] Sliding_Size,
  input  logic [15:0] InCol_Count_Times,
  input  logic [15:0] OutRow_Count_Times,
  input  logic [15:0] OutFeature_Channel_Count_Times,
  input  logic [15:0] OutCol_Count_Times,
  input  logic [15:0] Test_Generate_Period,
  output logic        Test_Signal,
  output logic        Test_End
);
  import img2col_pkg::*;
  localparam int BEAT_W = $clog2(MAX_ROW_BEATS);
  localparam int SLOT_W = $clog2(ROW_SLOTS);
  localparam int AW = SLOT_W + BEAT_W;
  st_t st_q, st_d;
  beat_t head;
  logic [DATA_W-1:0] rdata_q;
  logic ready_w, wr, rows_ok, room, issue, pop, mvalid, sel;
  logic last_wcol, last_beat, win_end, grp_end, row_end, last_r;
  logic unused_cfg;
  assign unused_cfg = ^{InFeature_Channel, OutFeature_Channel, OutFeature_Size, OutCol_Count_Times};
  assign head = st_q.fifo[st_q.head];
  assign mvalid = st_q.cnt != 2'd0;
  assign pop = mvalid && io.mReady;
  assign sel = {1'b0, head.tag.row} + 17'd1 == {1'b0, Test_Generate_Period};
  // Writer may run ahead of the current output row by at most ROW_SLOTS rows.
  assign ready_w = st_q.active && (st_q.wrow < InFeature_Size)
                 && ({2'b0, st_q.wrow} < {2'b0, st_q.rbase} + SUM_W'(ROW_SLOTS));
  assign wr = io.sData_valid && ready_w;
  assign rows_ok = {2'b0, st_q.wrow} >= {2'b0, st_q.rbase} + {10'b0, Kernel_Size};
  // Slots held by the skid buffer plus the read in flight, net of this cycle's pop.
  assign room = (st_q.cnt + {1'b0, st_q.infl} - {1'b0, pop}) < 2'd2;
  assign issue = st_q.active && (st_q.r < OutRow_Count_Times) && rows_ok && room;
  assign last_wcol = st_q.wcol == InCol_Count_Times - 16'd1;
  assign last_beat = st_q.beat == Window_Size - 16'd1;
  assign win_end = last_beat && (st_q.kr == {8'b0, Kernel_Size} - 16'd1);
  assign grp_end = win_end && (st_q.c == OutRow_Count_Times - 16'd1);
  assign row_end = grp_end && (st_q.oct == OutFeature_Channel_Count_Times - 16'd1);
  assign last_r = st_q.r == OutRow_Count_Times - 16'd1;
  always_comb begin
    st_d = st_q;
    if (wr) begin
      st_d.wcol = last_wcol ? '0 : st_q.wcol + 16'd1;
      st_d.wrow = last_wcol ? st_q.wrow + 16'd1 : st_q.wrow;
    end
    if (issue) begin
      st_d.beat = last_beat ? '0 : st_q.beat + 16'd1;
      st_d.kr = win_end ? '0 : last_beat ? st_q.kr + 16'd1 : st_q.kr;
      st_d.c = grp_end ? '0 : win_end ? st_q.c + 16'd1 : st_q.c;
      st_d.colbase = grp_end ? '0 : win_end ? st_q.colbase + Sliding_Size : st_q.colbase;
      st_d.oct = row_end ? '0 : grp_end ? st_q.oct + 16'd1 : st_q.oct;
      st_d.r = row_end ? st_q.r + 16'd1 : st_q.r;
      st_d.rbase = row_end ? st_q.rbase + {8'b0, Stride} : st_q.rbase;
    end
    st_d.infl = issue;
    st_d.infl_tag = '{last: row_end && last_r, row_end: row_end, row: st_q.r};
    if (st_q.infl) st_d.fifo[st_q.head ^ st_q.cnt[0]] = '{data: rdata_q, tag: st_q.infl_tag};
    st_d.cnt = st_q.cnt + {1'b0, st_q.infl} - {1'b0, pop};
    st_d.head = st_q.head ^ pop;
    st_d.test_end = pop && head.tag.row_end && sel;
    if (pop && head.tag.last) st_d.active = 1'b0;
    if (start) begin
      st_d = '0;
      st_d.active = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) st_q <= '0;
    else st_q <= st_d;
  end
  img2col_linebuf #(.AW(AW)) u_linebuf (
    .clk(clk),
    .we(wr),
    .waddr({SLOT_W'(st_q.wrow), BEAT_W'(st_q.wcol)}),
    .wdata(io.sData_payload),
    .re(issue),
    .raddr({SLOT_W'(st_q.rbase + st_q.kr), BEAT_W'(st_q.colbase + st_q.beat)}),
    .rdata_q(rdata_q)
  );
  assign io.sData_ready = ready_w;
  assign io.mValid = mvalid;
  assign io.mData = head.data;
  assign io.mLast = mvalid && head.tag.last;
  assign Test_Signal = mvalid && sel;
  assign Test_End = st_q.test_end;
endmodule

// File: tb/tb_img2col_top.sv
// tb_img2col_top: directed frames checked beat-by-beat against an img2col reference model.
module tb_img2col_top;
  localparam int TO = 3000;
  localparam int TO_FRAME = 20000;
  typedef struct {
    logic [63:0] d;
    bit last;
    bit row_end;
    int row;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] stride = '0, ksz = '0;
  logic [15:0] w = '0, ch = '0, ocf = '0, osz = '0, win = '0, sld = '0;
  logic [15:0] incol = '0, orow = '0, oct = '0, ocol = '0, tgp = '0;
  logic tsig, tend;
  exp_t exp_q[$];
  logic [63:0] img [0:15][0:31];
  logic [63:0] got_log [0:1023];
  logic [63:0] hold_d;
  int checks = 0, errors = 0, got_n = 0, ts_n = 0, tend_n = 0, rmode = 1, cyc = 0;
  bit chk_en = 0, frame_done = 0, te_exp = 0, hold_v = 0;
  img2col_if bus();
  img2col_top dut (
    .clk(clk), .rst(rst), .start(start), .io(bus),
    .Stride(stride), .Kernel_Size(ksz), .InFeature_Size(w), .InFeature_Channel(ch),
    .OutFeature_Channel(ocf), .OutFeature_Size(osz), .Window_Size(win), .Sliding_Size(sld),
    .InCol_Count_Times(incol), .OutRow_Count_Times(orow), .OutFeature_Channel_Count_Times(oct),
    .OutCol_Count_Times(ocol), .Test_Generate_Period(tgp), .Test_Signal(tsig), .Test_End(tend)
  );
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic set_cfg(input int k, input int s, input int c, input int wd, input int o_ct);
    ksz = 8'(k); stride = 8'(s); ch = 16'(c); w = 16'(wd);
    win = 16'(k * c / 8); sld = 16'(s * c / 8); incol = 16'(wd * c / 8);
    orow = 16'((wd - k) / s + 1); osz = orow; oct = 16'(o_ct);
    ocol = 16'((int'(orow) + 7) / 8); ocf = 16'(o_ct * 8);
  endtask

  task automatic fill(input bit rnd);
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < 32; b++)
        img[r][b] = rnd ? {$urandom, $urandom} : 64'(r * 16 + b);
  endtask

  // Reference order: channel group, then window, then kernel row, then window beats.
  task automatic build_exp;
    int k = int'(ksz), s = int'(stride), o = int'(orow), wn = int'(win), sl = int'(sld), q_n = int'(oct);
    exp_q.delete();
    for (int r = 0; r < o; r++)
      for (int q = 0; q < q_n; q++)
        for (int c = 0; c < o; c++)
          for (int kr = 0; kr < k; kr++)
            for (int b = 0; b < wn; b++) begin
              bit re = (q == q_n - 1) && (c == o - 1) && (kr == k - 1) && (b == wn - 1);
              exp_q.push_back('{d: img[r * s + kr][c * sl + b], last: re && (r == o - 1), row_end: re, row: r});
            end
  endtask

  initial begin
    bus.mReady = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.mReady = (rmode == 1) || (rmode == 2 && (cyc % 513) < 64) || (rmode == 3 && $urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!chk_en) begin
      got_n = 0; ts_n = 0; tend_n = 0; frame_done = 0; te_exp = 0; hold_v = 0;
    end else begin
      check("test_end", tend, te_exp);
      if (tend) tend_n++;
      te_exp = 0;
      if (hold_v) begin
        check("hold_valid", bus.mValid, 1);
        check("hold_data", bus.mData, hold_d);
      end
      hold_v = 0;
      if (!bus.mValid) check("test_signal_idle", tsig, 0);
      else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_beat actual=%h required=none", bus.mData);
      end else begin
        check("test_signal", tsig, exp_q[0].row + 1 == int'(tgp));
        if (bus.mReady) begin
          check("mdata", bus.mData, exp_q[0].d);
          check("mlast", bus.mLast, exp_q[0].last);
          if (got_n < 1024) got_log[got_n] = bus.mData;
          got_n++;
          if (tsig) ts_n++;
          te_exp = exp_q[0].row_end && (exp_q[0].row + 1 == int'(tgp));
          if (exp_q[0].last) frame_done = 1;
          void'(exp_q.pop_front());
        end else begin
          hold_v = 1;
          hold_d = bus.mData;
        end
      end
    end
  end

  task automatic produce(input int limit, input int gapm, output int n);
    n = 0;
    for (int r = 0; r < int'(w) && n < limit; r++)
      for (int b = 0; b < int'(incol) && n < limit; b++) begin
        int t;
        bit hs;
        while (gapm != 0 && $urandom_range(0, 3) == 0) begin
          bus.sData_valid = 1'b0;
          @(posedge clk); #1;
        end
        bus.sData_valid = 1'b1;
        bus.sData_payload = img[r][b];
        t = 0; hs = 0;
        while (!hs && t < TO) begin
          @(negedge clk); hs = bus.sData_ready;
          @(posedge clk); #1; t++;
        end
        if (!hs) begin
          checks++; errors++;
          $display("FAIL input_stall actual=blocked required=accepted row=%0d beat=%0d", r, b);
          bus.sData_valid = 1'b0;
          return;
        end
        n++;
      end
    bus.sData_valid = 1'b0;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input int gapm, output int n_got, output int n_ts, output int n_te);
    int n_exp;
    build_exp();
    n_exp = exp_q.size();
    @(posedge clk); #1 chk_en = 1;
    pulse_start();
    fork
      begin
        int n_in;
        produce(1 << 30, gapm, n_in);
      end
      begin
        int t = 0;
        while (!frame_done && t < TO_FRAME) begin
          @(negedge clk); t++;
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("frame_done", frame_done, 1);
    check("beat_count", got_n, n_exp);
    n_got = got_n; n_ts = ts_n; n_te = tend_n;
    chk_en = 0;
    @(negedge clk);
    check("idle_ready", bus.sData_ready, 0);
    check("idle_valid", bus.mValid, 0);
  endtask

  initial begin
    int n, nts, nte, nin;
    logic [63:0] lit9 [9];
    lit9 = '{64'h00, 64'h01, 64'h02, 64'h10, 64'h11, 64'h12, 64'h20, 64'h21, 64'h22};
    bus.sData_valid = 1'b0;
    bus.sData_payload = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.sData_ready, 0);
    check("rst_valid", bus.mValid, 0);
    check("rst_last", bus.mLast, 0);
    check("rst_data", bus.mData, 0);
    check("rst_tsig", tsig, 0);
    check("rst_tend", tend, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_start_ready", bus.sData_ready, 0);
    check("pre_start_valid", bus.mValid, 0);
    // K3 S1 C8 W5, full-rate sink, debug row 2
    set_cfg(3, 1, 8, 5, 1); fill(0); tgp = 16'd2; rmode = 1;
    run_frame(0, n, nts, nte);
    check("f1_beats", n, 81);
    for (int i = 0; i < 9; i++) check("f1_first9", got_log[i], lit9[i]);
    check("f1_tsig_beats", nts, 27);
    check("f1_tend_pulses", nte, 1);
    // OCT=2 repeats each row's 27-beat group, random sink stalls
    set_cfg(3, 1, 8, 5, 2); tgp = 16'd1; rmode = 3;
    run_frame(1, n, nts, nte);
    check("f2_beats", n, 162);
    for (int i = 0; i < 27; i++) check("f2_repeat", got_log[27 + i], 64'(((i % 9) / 3) * 16 + i / 9 + i % 3));
    check("f2_tsig_beats", nts, 54);
    check("f2_tend_pulses", nte, 1);
    // abort by a second start mid-frame, then bursty sink on a strided config
    set_cfg(3, 2, 16, 9, 2); fill(1); tgp = 16'd3; rmode = 1;
    pulse_start();
    produce(20, 0, nin);
    rmode = 2;
    run_frame(1, n, nts, nte);
    check("f3_beats", n, 576);
    check("f3_tend_pulses", nte, 1);
    // rst mid-frame discards everything until the next start
    rmode = 1;
    pulse_start();
    produce(30, 0, nin);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_valid", bus.mValid, 0);
      check("post_rst_ready", bus.sData_ready, 0);
    end
    tgp = 16'd4; rmode = 3;
    run_frame(1, n, nts, nte);
    check("f4_beats", n, 576);
    check("f4_tend_pulses", nte, 1);
    // blocked sink: writer stops after ROW_SLOTS rows and the first beat holds
    set_cfg(3, 1, 8, 10, 1); fill(1); rmode = 0;
    repeat (2) @(posedge clk);
    pulse_start();
    produce(80, 0, nin);
    check("stall_accepted", nin, 80);
    repeat (10) begin
      @(negedge clk);
      check("stall_ready", bus.sData_ready, 0);
      check("stall_valid", bus.mValid, 1);
      check("stall_data", bus.mData, img[0][0]);
      check("stall_last", bus.mLast, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
